// File: rtl/lap_stopwatch.sv
// Lap stopwatch clocked at one edge per second: H:M:S up/down counter with
// countdown preset, overflow/done flags and a show-ahead lap FIFO. All outputs are flops.
module lap_stopwatch #(
    parameter int HOUR_MAX  = 11,
    parameter int HOUR_W    = 4,
    parameter int LAP_DEPTH = 4
) (
    input  logic                        Clk_1sec,
    input  logic                        reset_n_in,
    input  logic                        stopwatch_on_in,
    input  logic                        stopwatch_reset_in,
    input  logic                        mode_down_in,
    input  logic                        load_in,
    input  logic [HOUR_W-1:0]           load_hour_in,
    input  logic [5:0]                  load_minute_in,
    input  logic [5:0]                  load_second_in,
    input  logic                        lap_in,
    input  logic                        lap_rd_in,
    output logic [HOUR_W-1:0]           stopwatch_hours_out,
    output logic [5:0]                  stopwatch_minutes_out,
    output logic [5:0]                  stopwatch_seconds_out,
    output logic [HOUR_W-1:0]           lap_hours_out,
    output logic [5:0]                  lap_minutes_out,
    output logic [5:0]                  lap_seconds_out,
    output logic [$clog2(LAP_DEPTH):0]  lap_count_out,
    output logic                        lap_empty_out,
    output logic                        lap_full_out,
    output logic                        lap_overrun_out,
    output logic                        overflow_out,
    output logic                        done_out,
    output logic                        running_out
);
    localparam int AW = $clog2(LAP_DEPTH);
    localparam int TW = HOUR_W + 12;
    localparam logic [HOUR_W-1:0] HMAX  = HOUR_W'(HOUR_MAX);
    localparam logic [AW:0]       DEPTH = (AW+1)'(LAP_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t            state_q, state_d;
    logic [HOUR_W-1:0] hr_q, hr_d, nh;
    logic [5:0]        min_q, min_d, sec_q, sec_d, nm, ns;
    logic              mode_q, mode_d, ovf_q, ovf_d, ovr_q, ovr_d;
    logic              done_q, run_q, empty_q, full_q;
    logic              wrap, advance, push, pop, wr_en, eff_down;
    logic [TW-1:0]     mem_q [LAP_DEPTH];
    logic [TW-1:0]     head_q, head_d, cur;
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]       cnt_q, cnt_d;

    function automatic logic [5:0] sat59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    function automatic logic [HOUR_W-1:0] sat_hour(input logic [HOUR_W-1:0] v);
        return (v > HMAX) ? HMAX : v;
    endfunction

    assign cur      = {hr_q, min_q, sec_q};
    // Direction is sampled live while stopped so the starting edge already uses it.
    assign eff_down = (state_q == IDLE || state_q == PAUSE) ? mode_down_in : mode_q;

    always_comb begin
        ns = sec_q; nm = min_q; nh = hr_q; wrap = 1'b0;
        if (!eff_down) begin
            if (sec_q < 6'd59) ns = sec_q + 6'd1;
            else begin
                ns = '0;
                if (min_q < 6'd59) nm = min_q + 6'd1;
                else begin
                    nm = '0;
                    if (hr_q < HMAX) nh = hr_q + HOUR_W'(1);
                    else begin
                        nh   = '0;
                        wrap = 1'b1;
                    end
                end
            end
        end else begin
            if (sec_q != '0) ns = sec_q - 6'd1;
            else begin
                ns = 6'd59;
                if (min_q != '0) nm = min_q - 6'd1;
                else begin
                    nm = 6'd59;
                    nh = (hr_q != '0) ? hr_q - HOUR_W'(1) : HMAX;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q; hr_d = hr_q; min_d = min_q; sec_d = sec_q;
        mode_d  = mode_q;  ovf_d = 1'b0; advance = 1'b0; push = 1'b0; pop = 1'b0;
        if (stopwatch_reset_in) begin
            state_d = IDLE; hr_d = '0; min_d = '0; sec_d = '0; mode_d = 1'b0;
        end else begin
            if (state_q == IDLE || state_q == PAUSE) mode_d = mode_down_in;
            if (load_in && state_q != RUN) begin
                hr_d  = sat_hour(load_hour_in);
                min_d = sat59(load_minute_in);
                sec_d = sat59(load_second_in);
                if (state_q == DONE) state_d = PAUSE;
            end else begin
                unique case (state_q)
                    IDLE, PAUSE: if (stopwatch_on_in) begin
                        state_d = RUN;
                        advance = 1'b1;
                    end
                    RUN: if (stopwatch_on_in) advance = 1'b1;
                         else state_d = PAUSE;
                    DONE: ;
                endcase
            end
            if (advance) begin
                hr_d = nh; min_d = nm; sec_d = ns;
                ovf_d = wrap;
                if (eff_down && {nh, nm, ns} == '0) state_d = DONE;
            end
            push = lap_in && (state_q == RUN || state_q == PAUSE);
            pop  = lap_rd_in && !empty_q;
        end
    end

    // FIFO bookkeeping; the head register is precomputed so the lap outputs are flops.
    always_comb begin
        rd_d = rd_q; wr_d = wr_q; cnt_d = cnt_q; ovr_d = ovr_q; wr_en = 1'b0;
        if (stopwatch_reset_in) begin
            rd_d = '0; wr_d = '0; cnt_d = '0; ovr_d = 1'b0;
        end else begin
            wr_en = push && (!full_q || pop);
            if (push && full_q && !pop) ovr_d = 1'b1;
            if (wr_en) wr_d = wr_q + AW'(1);
            if (pop)   rd_d = rd_q + AW'(1);
            if (wr_en && !pop)      cnt_d = cnt_q + (AW+1)'(1);
            else if (pop && !wr_en) cnt_d = cnt_q - (AW+1)'(1);
        end
        if (cnt_d == '0)                  head_d = '0;
        else if (wr_en && rd_d == wr_q)   head_d = cur;
        else                              head_d = mem_q[rd_d];
    end

    always_ff @(posedge Clk_1sec or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;  hr_q <= '0;    min_q <= '0;   sec_q <= '0;
            mode_q  <= 1'b0;  ovf_q <= 1'b0; ovr_q <= 1'b0;
            done_q  <= 1'b0;  run_q <= 1'b0;
            rd_q    <= '0;    wr_q <= '0;    cnt_q <= '0;   head_q <= '0;
            empty_q <= 1'b1;  full_q <= 1'b0;
        end else begin
            state_q <= state_d; hr_q <= hr_d;   min_q <= min_d; sec_q <= sec_d;
            mode_q  <= mode_d;  ovf_q <= ovf_d; ovr_q <= ovr_d;
            done_q  <= (state_d == DONE);
            run_q   <= (state_d == RUN);
            rd_q    <= rd_d;    wr_q <= wr_d;   cnt_q <= cnt_d; head_q <= head_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == DEPTH);
        end
    end

    always_ff @(posedge Clk_1sec) begin
        if (wr_en) mem_q[wr_q] <= cur;
    end

    assign stopwatch_hours_out   = hr_q;
    assign stopwatch_minutes_out = min_q;
    assign stopwatch_seconds_out = sec_q;
    assign lap_hours_out         = head_q[TW-1 -: HOUR_W];
    assign lap_minutes_out       = head_q[11:6];
    assign lap_seconds_out       = head_q[5:0];
    assign lap_count_out         = cnt_q;
    assign lap_empty_out         = empty_q;
    assign lap_full_out          = full_q;
    assign lap_overrun_out       = ovr_q;
    assign overflow_out          = ovf_q;
    assign done_out              = done_q;
    assign running_out           = run_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: table of {inputs, repeat, expected} vectors feeding a
// scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_lap_stopwatch;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       on = 1'b0, clr = 1'b0, down = 1'b0, load = 1'b0, lap = 1'b0, rd = 1'b0;
    logic [3:0] lh = '0;
    logic [5:0] lm = '0, ls = '0;
    logic [3:0] h_o, lh_o;
    logic [5:0] m_o, s_o, lm_o, ls_o;
    logic [2:0] cnt_o;
    logic       empty_o, full_o, ovr_o, ovf_o, done_o, run_o;

    always #5 clk = ~clk;

    lap_stopwatch #(.HOUR_MAX(11), .HOUR_W(4), .LAP_DEPTH(4)) dut (
        .Clk_1sec(clk), .reset_n_in(rst_n), .stopwatch_on_in(on),
        .stopwatch_reset_in(clr), .mode_down_in(down), .load_in(load),
        .load_hour_in(lh), .load_minute_in(lm), .load_second_in(ls),
        .lap_in(lap), .lap_rd_in(rd),
        .stopwatch_hours_out(h_o), .stopwatch_minutes_out(m_o), .stopwatch_seconds_out(s_o),
        .lap_hours_out(lh_o), .lap_minutes_out(lm_o), .lap_seconds_out(ls_o),
        .lap_count_out(cnt_o), .lap_empty_out(empty_o), .lap_full_out(full_o),
        .lap_overrun_out(ovr_o), .overflow_out(ovf_o), .done_out(done_o), .running_out(run_o)
    );

    typedef struct packed {
        logic on, clr, down, load, lap, rd;
        logic [3:0] lh;
        logic [5:0] lm, ls;
    } in_t;

    typedef struct packed {
        logic [3:0] h;  logic [5:0] m, s;
        logic [3:0] lh; logic [5:0] lm, ls;
        logic [2:0] cnt;
        logic empty, full, ovr, ovf, done, run;
    } out_t;

    typedef struct { in_t i; int reps; out_t e; string nm; } vec_t;
    typedef struct { out_t e; string nm; } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    sb_t  mon_r;
    int   total  = 0;
    int   passed = 0;

    function automatic in_t In(input logic o, c, d, l, r);
        in_t v = '0;
        v.on = o; v.clr = c; v.down = d; v.lap = l; v.rd = r;
        return v;
    endfunction

    function automatic in_t Ld(input logic o, d, input int h, m, s);
        in_t v = '0;
        v.on = o; v.down = d; v.load = 1'b1;
        v.lh = 4'(h); v.lm = 6'(m); v.ls = 6'(s);
        return v;
    endfunction

    function automatic out_t O(input int h, m, s, qh, qm, qs, c,
                               input logic e, f, ov, of, dn, rn);
        out_t r;
        r.h = 4'(h); r.m = 6'(m); r.s = 6'(s);
        r.lh = 4'(qh); r.lm = 6'(qm); r.ls = 6'(qs); r.cnt = 3'(c);
        r.empty = e; r.full = f; r.ovr = ov; r.ovf = of; r.done = dn; r.run = rn;
        return r;
    endfunction

    function automatic out_t sample();
        out_t r;
        r.h = h_o; r.m = m_o; r.s = s_o; r.lh = lh_o; r.lm = lm_o; r.ls = ls_o;
        r.cnt = cnt_o; r.empty = empty_o; r.full = full_o; r.ovr = ovr_o;
        r.ovf = ovf_o; r.done = done_o; r.run = run_o;
        return r;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("%0d:%0d:%0d lap=%0d:%0d:%0d cnt=%0d empty=%0b full=%0b ovr=%0b ovf=%0b done=%0b run=%0b",
                         o.h, o.m, o.s, o.lh, o.lm, o.ls, o.cnt, o.empty, o.full,
                         o.ovr, o.ovf, o.done, o.run);
    endfunction

    task automatic compare(input string nm, input out_t got, input out_t exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(exp));
    endtask

    task automatic drive(input in_t v);
        @(negedge clk);
        on = v.on; clr = v.clr; down = v.down; load = v.load; lap = v.lap; rd = v.rd;
        lh = v.lh; lm = v.lm; ls = v.ls;
    endtask

    task automatic add(input in_t i, input int reps, input out_t e, input string nm);
        tbl.push_back('{i: i, reps: reps, e: e, nm: nm});
    endtask

    // Scoreboard consumer: one expectation per edge, sampled just after it.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_r = sb.pop_front();
            compare(mon_r.nm, sample(), mon_r.e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_t ZERO;
        ZERO = O(0,0,0, 0,0,0, 0, 1,0,0,0,0,0);

        // Up count and pause
        add(In(0,1,0,0,0),  1, ZERO,                                    "clr_idle");
        add(In(1,0,0,0,0), 75, O(0,1,15, 0,0,0, 0, 1,0,0,0,0,1),        "up_75");
        add(In(0,0,0,0,0),  1, O(0,1,15, 0,0,0, 0, 1,0,0,0,0,0),        "pause_enter");
        add(In(0,0,0,0,0),  5, O(0,1,15, 0,0,0, 0, 1,0,0,0,0,0),        "pause_hold");
        add(In(0,1,0,0,0),  1, ZERO,                                    "clr_pause");
        add(In(1,0,0,0,0), 20, O(0,0,20, 0,0,0, 0, 1,0,0,0,0,1),        "run20");
        add(In(0,0,0,0,0), 10, O(0,0,20, 0,0,0, 0, 1,0,0,0,0,0),        "pause10");
        add(In(1,0,0,0,0),  1, O(0,0,21, 0,0,0, 0, 1,0,0,0,0,1),        "resume");
        add(In(1,0,1,0,0), 28, O(0,0,49, 0,0,0, 0, 1,0,0,0,0,1),        "mode_toggle_in_run");
        add(In(1,0,0,0,0),  1, O(0,0,50, 0,0,0, 0, 1,0,0,0,0,1),        "run30_total50");
        // Wrap, saturation, load ignored while running
        add(In(0,1,0,0,0),  1, ZERO,                                    "clr_wrap");
        add(Ld(0,0,11,59,58), 1, O(11,59,58, 0,0,0, 0, 1,0,0,0,0,0),    "load_idle");
        add(In(1,0,0,0,0),  1, O(11,59,59, 0,0,0, 0, 1,0,0,0,0,1),      "wrap_edge1");
        add(In(1,0,0,0,0),  1, O(0,0,0, 0,0,0, 0, 1,0,0,1,0,1),         "wrap_edge2_ovf");
        add(In(1,0,0,0,0),  1, O(0,0,1, 0,0,0, 0, 1,0,0,0,0,1),         "wrap_edge3");
        add(In(0,0,0,0,0),  1, O(0,0,1, 0,0,0, 0, 1,0,0,0,0,0),         "pause_b");
        add(Ld(0,0,15,63,60), 1, O(11,59,59, 0,0,0, 0, 1,0,0,0,0,0),    "load_saturate");
        add(In(1,0,0,0,0),  1, O(0,0,0, 0,0,0, 0, 1,0,0,1,0,1),         "wrap_again_ovf");
        add(Ld(1,0,1,2,3),  1, O(0,0,1, 0,0,0, 0, 1,0,0,0,0,1),         "load_in_run_ignored");
        // Countdown to DONE
        add(In(0,1,0,0,0),  1, ZERO,                                    "clr_cd");
        add(Ld(0,1,0,0,3),  1, O(0,0,3, 0,0,0, 0, 1,0,0,0,0,0),         "load_countdown");
        add(In(1,0,1,0,0),  2, O(0,0,1, 0,0,0, 0, 1,0,0,0,0,1),         "countdown_2");
        add(In(1,0,1,0,0),  1, O(0,0,0, 0,0,0, 0, 1,0,0,0,1,0),         "countdown_done");
        add(In(1,0,1,1,0),  3, O(0,0,0, 0,0,0, 0, 1,0,0,0,1,0),         "done_hold_lap_ignored");
        add(Ld(1,0,0,0,5),  1, O(0,0,5, 0,0,0, 0, 1,0,0,0,0,0),         "load_from_done");
        add(In(1,0,0,0,0),  1, O(0,0,6, 0,0,0, 0, 1,0,0,0,0,1),         "resume_up_after_done");
        // Laps: fill, overrun, read back in order
        add(In(0,1,0,0,0),  1, ZERO,                                    "clr_laps");
        add(In(1,0,0,0,0),  3, O(0,0,3, 0,0,0, 0, 1,0,0,0,0,1),         "laps_run3");
        add(In(1,0,0,1,0),  1, O(0,0,4, 0,0,3, 1, 0,0,0,0,0,1),         "lap1");
        add(In(1,0,0,0,0),  2, O(0,0,6, 0,0,3, 1, 0,0,0,0,0,1),         "lap_gap");
        add(In(1,0,0,1,0),  1, O(0,0,7, 0,0,3, 2, 0,0,0,0,0,1),         "lap2");
        add(In(1,0,0,1,0),  1, O(0,0,8, 0,0,3, 3, 0,0,0,0,0,1),         "lap3");
        add(In(1,0,0,0,0),  2, O(0,0,10, 0,0,3, 3, 0,0,0,0,0,1),        "lap_gap2");
        add(In(1,0,0,1,0),  1, O(0,0,11, 0,0,3, 4, 0,1,0,0,0,1),        "lap4_full");
        add(In(1,0,0,0,0),  1, O(0,0,12, 0,0,3, 4, 0,1,0,0,0,1),        "lap_gap3");
        add(In(1,0,0,1,0),  1, O(0,0,13, 0,0,3, 4, 0,1,1,0,0,1),        "lap5_overrun");
        add(In(0,0,0,0,0),  1, O(0,0,13, 0,0,3, 4, 0,1,1,0,0,0),        "laps_pause");
        add(In(0,0,0,0,1),  1, O(0,0,13, 0,0,6, 3, 0,0,1,0,0,0),        "pop1");
        add(In(0,0,0,0,1),  1, O(0,0,13, 0,0,7, 2, 0,0,1,0,0,0),        "pop2");
        add(In(0,0,0,0,1),  1, O(0,0,13, 0,0,10, 1, 0,0,1,0,0,0),       "pop3");
        add(In(0,0,0,0,1),  1, O(0,0,13, 0,0,0, 0, 1,0,1,0,0,0),        "pop4_empty");
        add(In(0,0,0,0,1),  1, O(0,0,13, 0,0,0, 0, 1,0,1,0,0,0),        "pop_on_empty");
        add(In(0,0,0,1,1),  1, O(0,0,13, 0,0,13, 1, 0,0,1,0,0,0),       "push_pop_empty");
        // Simultaneous push/pop when full, then clear with laps stored
        add(In(0,1,0,0,0),  1, ZERO,                                    "clr_laps2");
        add(In(0,0,0,1,0),  1, ZERO,                                    "lap_idle_ignored");
        add(In(1,0,0,1,0),  1, O(0,0,1, 0,0,0, 0, 1,0,0,0,0,1),         "lap_on_start_edge");
        add(In(1,0,0,1,0),  1, O(0,0,2, 0,0,1, 1, 0,0,0,0,0,1),         "lapb1");
        add(In(1,0,0,1,0),  1, O(0,0,3, 0,0,1, 2, 0,0,0,0,0,1),         "lapb2");
        add(In(1,0,0,1,0),  1, O(0,0,4, 0,0,1, 3, 0,0,0,0,0,1),         "lapb3");
        add(In(1,0,0,1,0),  1, O(0,0,5, 0,0,1, 4, 0,1,0,0,0,1),         "lapb4_full");
        add(In(1,0,0,1,1),  1, O(0,0,6, 0,0,2, 4, 0,1,0,0,0,1),         "push_pop_full");
        add(In(1,0,0,0,1),  1, O(0,0,7, 0,0,3, 3, 0,0,0,0,0,1),         "popb1");
        add(In(1,0,0,0,1),  1, O(0,0,8, 0,0,4, 2, 0,0,0,0,0,1),         "popb2");
        add(In(1,1,0,0,0),  1, ZERO,                                    "clr_mid_run");
        add(In(0,0,0,0,0),  1, ZERO,                                    "idle_after_clr");

        #1 rst_n = 1'b0;
        #1 compare("reset_state", sample(), ZERO);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            for (int r = 0; r < tbl[k].reps; r++) drive(tbl[k].i);
            sb.push_back('{e: tbl[k].e, nm: tbl[k].nm});
        end

        // Asynchronous reset mid-RUN with a lap push pending on the next edge
        for (int r = 0; r < 3; r++) drive(In(1,0,0,0,0));
        drive(In(1,0,0,1,0));
        sb.push_back('{e: O(0,0,4, 0,0,3, 1, 0,0,0,0,0,1), nm: "pre_async_reset"});
        drive(In(1,0,0,1,0));
        #2 rst_n = 1'b0;
        #1 compare("async_reset_immediate", sample(), ZERO);
        @(negedge clk);
        compare("async_reset_held_over_push", sample(), ZERO);
        on = 1'b0; lap = 1'b0;
        rst_n = 1'b1;
        drive(In(0,0,0,0,0));
        sb.push_back('{e: ZERO, nm: "post_reset_idle"});
        drive(In(1,0,0,0,0));
        sb.push_back('{e: O(0,0,1, 0,0,0, 0, 1,0,0,0,0,1), nm: "first_count_after_reset"});

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
